// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator
// Turns a 1-bit PDM microphone stream into signed PCM samples with a
// 4th-order CIC decimator (differential delay 1, decimation ratio DECIM).
// The four integrators run on every PDM strobe. Once every DECIM strobes the
// last integrator is captured. A small sequencer then runs the four comb
// stages, one per clock, and registers the result onto a valid/ready output.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high; clears every register
//   pdm_bit      captured PDM sample (1 -> +1, 0 -> -1)
//   pdm_strobe   one-cycle pulse marking pdm_bit as valid
//   pcm_ready    consumer accepts pcm_data this cycle
//   overrun_clr  clears the sticky overrun flag
//   pcm_data     signed PCM sample, the top OUT_W bits of the comb output
//   pcm_valid    pcm_data valid; held until accepted
//   overrun      sticky; an unaccepted sample was overwritten
module pdm_cic_decimator #(
    parameter int DECIM      = 64,
    parameter int DECIM_LOG2 = 6,
    parameter int ACC_W      = 26,
    parameter int OUT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pdm_bit,
    input  logic             pdm_strobe,
    input  logic             pcm_ready,
    input  logic             overrun_clr,
    output logic [OUT_W-1:0] pcm_data,
    output logic             pcm_valid,
    output logic             overrun
);

    typedef enum logic [2:0] {IDLE, C1, C2, C3, C4, EMIT} state_t;

    state_t                    state_q, state_d;
    logic [3:0][ACC_W-1:0]     integ_q, integ_d;
    logic [3:0][ACC_W-1:0]     dly_q, dly_d;
    logic [ACC_W-1:0]          snap_q, snap_d;
    // One working register carries each comb result into the next stage.
    logic [ACC_W-1:0]          comb_q, comb_d;
    logic [DECIM_LOG2-1:0]     cnt_q, cnt_d;
    logic [2:0]                warm_q, warm_d;
    logic [OUT_W-1:0]          pcm_data_q, pcm_data_d;
    logic                      pcm_valid_q, pcm_valid_d;
    logic                      overrun_q, overrun_d;
    logic [ACC_W-1:0]          x_in;

    assign x_in = pdm_bit ? ACC_W'(1) : {ACC_W{1'b1}};

    always_comb begin
        state_d     = state_q;
        integ_d     = integ_q;
        dly_d       = dly_q;
        snap_d      = snap_q;
        comb_d      = comb_q;
        cnt_d       = cnt_q;
        warm_d      = warm_q;
        pcm_data_d  = pcm_data_q;
        pcm_valid_d = pcm_valid_q;
        overrun_d   = overrun_q;

        if (pcm_valid_q && pcm_ready) begin
            pcm_valid_d = 1'b0;
        end
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: ;
            C1: begin
                comb_d   = snap_q - dly_q[0];
                dly_d[0] = snap_q;
                state_d  = C2;
            end
            C2: begin
                comb_d   = comb_q - dly_q[1];
                dly_d[1] = comb_q;
                state_d  = C3;
            end
            C3: begin
                comb_d   = comb_q - dly_q[2];
                dly_d[2] = comb_q;
                state_d  = C4;
            end
            C4: begin
                comb_d   = comb_q - dly_q[3];
                dly_d[3] = comb_q;
                state_d  = EMIT;
            end
            EMIT: begin
                state_d = IDLE;
                // The first four results still carry the start-up transient.
                if (warm_q != 3'd4) begin
                    warm_d = warm_q + 3'd1;
                end else begin
                    pcm_data_d  = comb_q[ACC_W-1 -: OUT_W];
                    pcm_valid_d = 1'b1;
                    // Setting after the clear lets a new overrun beat overrun_clr.
                    if (pcm_valid_q && !pcm_ready) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Every stage uses the pre-update value of the stage before it.
        if (pdm_strobe) begin
            integ_d[0] = integ_q[0] + x_in;
            for (int k = 1; k < 4; k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            cnt_d = cnt_q + 1'b1;
            // Captures are DECIM strobes apart, so the sequencer is always idle here.
            if (cnt_q == DECIM_LOG2'(DECIM - 1)) begin
                snap_d  = integ_q[3] + integ_q[2];
                state_d = C1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            integ_q     <= '0;
            dly_q       <= '0;
            snap_q      <= '0;
            comb_q      <= '0;
            cnt_q       <= '0;
            warm_q      <= '0;
            pcm_data_q  <= '0;
            pcm_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            integ_q     <= integ_d;
            dly_q       <= dly_d;
            snap_q      <= snap_d;
            comb_q      <= comb_d;
            cnt_q       <= cnt_d;
            warm_q      <= warm_d;
            pcm_data_q  <= pcm_data_d;
            pcm_valid_q <= pcm_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign pcm_data  = pcm_data_q;
    assign pcm_valid = pcm_valid_q;
    assign overrun   = overrun_q;

endmodule
